// File: rtl/mem_io_responder.sv
// Bus target for the CPU byte bus: byte RAM plus memory-mapped UART FIFOs, a
// free-running cycle counter with a snapshot register, and a sticky stop flag.
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] bus_a_i,
    input  logic        bus_wr_i,
    input  logic [7:0]  bus_dout_i,
    output logic [7:0]  bus_din_o,
    output logic        rdy_o,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        stop_o
);

    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam logic [TX_PW:0] TX_FULL_CNT = (TX_PW+1)'(TX_DEPTH);
    localparam logic [RX_PW:0] RX_FULL_CNT = (RX_PW+1)'(RX_DEPTH);

    logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];

    logic [7:0]       tx_mem [0:TX_DEPTH-1];
    logic [TX_PW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [TX_PW:0]   tx_count_reg;

    logic [7:0]       rx_mem [0:RX_DEPTH-1];
    logic [RX_PW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [RX_PW:0]   rx_count_reg;

    logic [31:0] cycle_cnt_reg;
    logic [31:8] snapshot_reg;
    logic        stop_reg;
    logic [7:0]  bus_din_reg;

    logic        io_sel, accept, tx_full, rx_full, rx_empty;
    logic        tx_push, tx_pop, rx_push, rx_pop, ram_we;
    logic [2:0]  io_off;
    logic [7:0]  tx_push_data, io_rdata;
    logic        unused_addr_bits;

    assign unused_addr_bits = &{1'b0, bus_a_i[31:18]};

    assign io_sel   = (bus_a_i[17:16] == 2'b11);
    assign io_off   = bus_a_i[2:0];
    assign tx_full  = (tx_count_reg == TX_FULL_CNT);
    assign rx_full  = (rx_count_reg == RX_FULL_CNT);
    assign rx_empty = (rx_count_reg == '0);

    // A full TX FIFO freezes the CPU; every side effect is gated on accept.
    assign rdy_o  = ~tx_full;
    assign accept = rdy_o;

    assign ram_we  = accept & bus_wr_i & ~io_sel;
    // Offset 4 pushes a literal 0x00 so the sink sees an end marker.
    assign tx_push = accept & bus_wr_i & io_sel &
                     (((io_off == 3'd0) && (bus_dout_i != 8'h00)) || (io_off == 3'd4));
    assign tx_push_data = (io_off == 3'd4) ? 8'h00 : bus_dout_i;
    assign tx_pop  = tx_valid_o & tx_ready_i;
    assign rx_push = rx_valid_i & ~rx_full;
    assign rx_pop  = accept & ~bus_wr_i & io_sel & (io_off == 3'd0) & ~rx_empty;

    assign tx_valid_o = (tx_count_reg != '0);
    assign tx_data_o  = tx_mem[tx_rd_ptr_reg];
    assign rx_ready_o = ~rx_full;
    assign stop_o     = stop_reg;
    assign bus_din_o  = bus_din_reg;

    always_comb begin
        io_rdata = 8'h00;
        case (io_off)
            3'd0:    io_rdata = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];
            3'd4:    io_rdata = cycle_cnt_reg[7:0];
            3'd5:    io_rdata = snapshot_reg[15:8];
            3'd6:    io_rdata = snapshot_reg[23:16];
            3'd7:    io_rdata = snapshot_reg[31:24];
            default: io_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (ram_we)
            ram[bus_a_i[ADDR_WIDTH-1:0]] <= bus_dout_i;
        if (tx_push)
            tx_mem[tx_wr_ptr_reg] <= tx_push_data;
        if (rx_push)
            rx_mem[rx_wr_ptr_reg] <= rx_data_i;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus_din_reg <= 8'h00;
        end else if (accept && !bus_wr_i) begin
            bus_din_reg <= io_sel ? io_rdata : ram[bus_a_i[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count_reg <= tx_count_reg + 1'b1;
                2'b01:   tx_count_reg <= tx_count_reg - 1'b1;
                default: tx_count_reg <= tx_count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
                2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
                default: rx_count_reg <= rx_count_reg;
            endcase
        end
    end

    // Byte 0 of the snapshot is never read back, so only [31:8] is kept.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_cnt_reg <= 32'h0;
            snapshot_reg  <= '0;
            stop_reg      <= 1'b0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'h1;
            if (accept && io_sel && (io_off == 3'd4)) begin
                if (bus_wr_i)
                    stop_reg <= 1'b1;
                else
                    snapshot_reg <= cycle_cnt_reg[31:8];
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, UART FIFOs, counter snapshot,
// stop flag, TX back-pressure and mid-traffic reset.
module tb_mem_io_responder;

    localparam int TX_DEPTH = 8;
    localparam logic [31:0] IDLE_A = 32'h0003_0001;
    localparam logic [31:0] UART_A = 32'h0003_0000;
    localparam logic [31:0] CNT_A  = 32'h0003_0004;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] bus_a_i = IDLE_A;
    logic        bus_wr_i = 1'b0;
    logic [7:0]  bus_dout_i = 8'h00;
    logic [7:0]  bus_din_o;
    logic        rdy_o;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b0;
    logic        stop_o;

    int n_vec = 0;
    int n_err = 0;

    mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .bus_a_i(bus_a_i), .bus_wr_i(bus_wr_i), .bus_dout_i(bus_dout_i),
        .bus_din_o(bus_din_o), .rdy_o(rdy_o),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .stop_o(stop_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_op(input logic [31:0] a, input logic w, input logic [7:0] d);
        @(negedge clk_in);
        bus_a_i = a; bus_wr_i = w; bus_dout_i = d;
        @(posedge clk_in); #1;
        bus_a_i = IDLE_A; bus_wr_i = 1'b0;
    endtask

    task automatic tx_expect(input logic [7:0] e, input string tag);
        @(negedge clk_in); #1;
        check_vec({tag, "_valid"}, {31'h0, tx_valid_o}, 32'h1);
        check_vec(tag, {24'h0, tx_data_o}, {24'h0, e});
        tx_ready_i = 1'b1;
        @(posedge clk_in); #1;
        tx_ready_i = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge clk_in);
        rx_valid_i = 1'b1; rx_data_i = d;
        @(posedge clk_in); #1;
        rx_valid_i = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check_vec("rst_din",   {24'h0, bus_din_o}, 32'h0);
        check_vec("rst_rdy",   {31'h0, rdy_o}, 32'h1);
        check_vec("rst_txv",   {31'h0, tx_valid_o}, 32'h0);
        check_vec("rst_rxr",   {31'h0, rx_ready_o}, 32'h1);
        check_vec("rst_stop",  {31'h0, stop_o}, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // 1: RAM write then read, one-cycle read latency
        bus_op(32'h0000_0123, 1'b1, 8'hA5);
        check_vec("ram_wr_hold", {24'h0, bus_din_o}, 32'h0);
        bus_op(32'h0000_0123, 1'b0, 8'h00);
        check_vec("ram_rd", {24'h0, bus_din_o}, 32'hA5);
        bus_op(32'h0000_1FFFF, 1'b1, 8'h3C);
        bus_op(32'h0000_1FFFF, 1'b0, 8'h00);
        check_vec("ram_rd_top", {24'h0, bus_din_o}, 32'h3C);

        // 2: UART TX with 0x00 filter, then stop write
        bus_op(UART_A, 1'b1, 8'h41);
        bus_op(UART_A, 1'b1, 8'h00);
        bus_op(UART_A, 1'b1, 8'h42);
        tx_expect(8'h41, "tx_a");
        tx_expect(8'h42, "tx_b");
        @(negedge clk_in); #1;
        check_vec("tx_empty", {31'h0, tx_valid_o}, 32'h0);
        bus_op(CNT_A, 1'b1, 8'h99);
        check_vec("stop_set", {31'h0, stop_o}, 32'h1);
        tx_expect(8'h00, "tx_stop0");
        check_vec("stop_hold", {31'h0, stop_o}, 32'h1);

        // 3: fill TX, stall the extra write, release with one pop
        for (int i = 0; i < TX_DEPTH; i++) begin
            bus_op(UART_A, 1'b1, 8'h10 + 8'(i));
            check_vec($sformatf("fill_rdy%0d", i), {31'h0, rdy_o},
                      (i == TX_DEPTH-1) ? 32'h0 : 32'h1);
        end
        @(negedge clk_in);
        bus_a_i = UART_A; bus_wr_i = 1'b1; bus_dout_i = 8'h18;
        repeat (2) begin
            @(posedge clk_in); #1;
            check_vec("stall_rdy", {31'h0, rdy_o}, 32'h0);
        end
        @(negedge clk_in); #1;
        check_vec("stall_head", {24'h0, tx_data_o}, 32'h10);
        tx_ready_i = 1'b1;
        @(posedge clk_in); #1;
        tx_ready_i = 1'b0;
        check_vec("pop_rdy", {31'h0, rdy_o}, 32'h1);
        @(posedge clk_in); #1;
        check_vec("held_acc_rdy", {31'h0, rdy_o}, 32'h0);
        bus_a_i = IDLE_A; bus_wr_i = 1'b0;
        for (int i = 1; i <= TX_DEPTH; i++)
            tx_expect(8'h10 + 8'(i), $sformatf("drain%0d", i));
        @(negedge clk_in); #1;
        check_vec("drain_empty", {31'h0, tx_valid_o}, 32'h0);
        check_vec("drain_rdy", {31'h0, rdy_o}, 32'h1);

        // 4: RX reads, empty read, simultaneous push+pop on empty
        bus_op(UART_A, 1'b0, 8'h00);
        check_vec("rx_empty_rd", {24'h0, bus_din_o}, 32'h0);
        rx_push(8'h37);
        bus_op(UART_A, 1'b0, 8'h00);
        check_vec("rx_rd", {24'h0, bus_din_o}, 32'h37);
        bus_op(UART_A, 1'b0, 8'h00);
        check_vec("rx_rd_again", {24'h0, bus_din_o}, 32'h0);
        @(negedge clk_in);
        rx_valid_i = 1'b1; rx_data_i = 8'h5A; bus_a_i = UART_A; bus_wr_i = 1'b0;
        @(posedge clk_in); #1;
        rx_valid_i = 1'b0; bus_a_i = IDLE_A;
        check_vec("rx_pushpop_empty", {24'h0, bus_din_o}, 32'h0);
        bus_op(UART_A, 1'b0, 8'h00);
        check_vec("rx_queued", {24'h0, bus_din_o}, 32'h5A);
        for (int i = 0; i < 8; i++) rx_push(8'h80 + 8'(i));
        check_vec("rx_full", {31'h0, rx_ready_o}, 32'h0);

        // 5: counter snapshot across advancing counter, then wrap
        @(negedge clk_in);
        force dut.cycle_cnt_reg = 32'h0000_01FF;
        release dut.cycle_cnt_reg;
        bus_a_i = CNT_A; bus_wr_i = 1'b0;
        @(posedge clk_in); #1;
        bus_a_i = IDLE_A;
        check_vec("cnt_b0", {24'h0, bus_din_o}, 32'hFF);
        bus_op(32'h0003_0005, 1'b0, 8'h00);
        check_vec("cnt_b1", {24'h0, bus_din_o}, 32'h01);
        bus_op(32'h0003_0006, 1'b0, 8'h00);
        check_vec("cnt_b2", {24'h0, bus_din_o}, 32'h00);
        bus_op(32'h0003_0007, 1'b0, 8'h00);
        check_vec("cnt_b3", {24'h0, bus_din_o}, 32'h00);
        @(negedge clk_in);
        force dut.cycle_cnt_reg = 32'hFFFF_FFFF;
        release dut.cycle_cnt_reg;
        @(posedge clk_in); #1;
        check_vec("cnt_wrap", dut.cycle_cnt_reg, 32'h0);

        // 6: reset with both FIFOs busy and a read in flight
        bus_op(UART_A, 1'b1, 8'h77);
        bus_op(UART_A, 1'b0, 8'h00);
        check_vec("pre_rst_rx", {24'h0, bus_din_o}, 32'h80);
        check_vec("pre_rst_txv", {31'h0, tx_valid_o}, 32'h1);
        @(negedge clk_in);
        rst_in = 1'b1; bus_a_i = UART_A; bus_wr_i = 1'b0;
        @(posedge clk_in); #1;
        check_vec("mid_rst_txv",  {31'h0, tx_valid_o}, 32'h0);
        check_vec("mid_rst_din",  {24'h0, bus_din_o}, 32'h0);
        check_vec("mid_rst_stop", {31'h0, stop_o}, 32'h0);
        check_vec("mid_rst_rdy",  {31'h0, rdy_o}, 32'h1);
        check_vec("mid_rst_rxr",  {31'h0, rx_ready_o}, 32'h1);
        @(negedge clk_in);
        rst_in = 1'b0; bus_a_i = IDLE_A;
        bus_op(UART_A, 1'b0, 8'h00);
        check_vec("post_rst_rx", {24'h0, bus_din_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
